// File: rtl/y86_pkg.sv
// Shared Y86-64 encoding constants, encoder state type and byte-select helper.
package y86_pkg;

  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_CMOV   = 4'h2;
  localparam logic [3:0] I_IRMOV  = 4'h3;
  localparam logic [3:0] I_RMMOV  = 4'h4;
  localparam logic [3:0] I_MRMOV  = 4'h5;
  localparam logic [3:0] I_OP     = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSH   = 4'hA;
  localparam logic [3:0] I_POP    = 4'hB;

  localparam logic [3:0] REG_NONE = 4'hF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EMIT = 2'd1,
    STOP = 2'd2
  } y86_enc_state_t;

  // Byte idx of an encoded instruction: opcode, optional register byte, then valC little-endian.
  function automatic logic [7:0] instr_byte(
    input logic [3:0]  icode,
    input logic [3:0]  ifun,
    input logic [3:0]  ra,
    input logic [3:0]  rb,
    input logic [63:0] valc,
    input logic        has_regs,
    input logic        has_valc,
    input logic [3:0]  idx
  );
    logic [2:0]  vidx;
    logic [63:0] shifted;
    vidx    = 3'(idx - (has_regs ? 4'd2 : 4'd1));
    shifted = valc >> {vidx, 3'b000};
    if (idx == 4'd0) begin
      return {icode, ifun};
    end else if (has_regs && (idx == 4'd1)) begin
      return {ra, rb};
    end else if (has_valc) begin
      return shifted[7:0];
    end else begin
      return 8'h00;
    end
  endfunction

endpackage

// File: rtl/y86_instr_encoder_if.sv
// Instruction input handshake plus instruction-memory byte write port.
interface y86_instr_encoder_if #(
  parameter int unsigned ADDR_W = 64
);
  logic              in_valid;
  logic              in_ready;
  logic [3:0]        in_icode;
  logic [3:0]        in_ifun;
  logic [3:0]        in_rA;
  logic [3:0]        in_rB;
  logic [63:0]       in_valC;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [7:0]        wr_data;

  modport master (
    output in_valid, in_icode, in_ifun, in_rA, in_rB, in_valC,
    input  in_ready, wr_en, wr_addr, wr_data
  );

  modport slave (
    input  in_valid, in_icode, in_ifun, in_rA, in_rB, in_valC,
    output in_ready, wr_en, wr_addr, wr_data
  );
endinterface

// File: rtl/y86_instr_len.sv
// Instruction length and field-presence lookup by icode; shared with the fetch stage.
module y86_instr_len
  import y86_pkg::*;
(
  input  logic [3:0] icode,
  output logic [3:0] len,
  output logic       has_regs,
  output logic       has_valc,
  output logic       valid
);

  // Length table: opcode byte, plus register byte, plus 8 bytes of valC where present.
  always_comb begin
    len      = 4'd0;
    has_regs = 1'b0;
    has_valc = 1'b0;
    valid    = 1'b0;
    case (icode)
      I_HALT, I_NOP, I_RET: begin
        len   = 4'd1;
        valid = 1'b1;
      end
      I_CMOV, I_OP, I_PUSH, I_POP: begin
        len      = 4'd2;
        has_regs = 1'b1;
        valid    = 1'b1;
      end
      I_IRMOV, I_RMMOV, I_MRMOV: begin
        len      = 4'd10;
        has_regs = 1'b1;
        has_valc = 1'b1;
        valid    = 1'b1;
      end
      I_JXX, I_CALL: begin
        len      = 4'd9;
        has_valc = 1'b1;
        valid    = 1'b1;
      end
      default: begin
        len      = 4'd0;
        has_regs = 1'b0;
        has_valc = 1'b0;
        valid    = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/y86_instr_encoder.sv
// Y86-64 instruction encoder: serialises one accepted instruction into
// consecutive instruction-memory byte writes, one byte per clock.
module y86_instr_encoder
  import y86_pkg::*;
#(
  parameter int unsigned       ADDR_W     = 64,
  parameter int unsigned       MEM_SIZE   = 1024,
  parameter logic [ADDR_W-1:0] START_ADDR = {ADDR_W{1'b0}}
) (
  input  logic               clk,
  input  logic               rst_n,
  y86_instr_encoder_if.slave bus,
  output logic [ADDR_W-1:0]  next_pc,
  output logic               halted,
  output logic               mem_error,
  output logic               instr_invalid,
  output logic [31:0]        instr_count
);

  localparam logic [ADDR_W:0] MEM_LIMIT = (ADDR_W+1)'(MEM_SIZE);

  y86_enc_state_t    state_r;
  logic [3:0]        icode_r;
  logic [3:0]        ifun_r;
  logic [3:0]        ra_r;
  logic [3:0]        rb_r;
  logic [63:0]       valc_r;
  logic [3:0]        len_r;
  logic              regs_r;
  logic              valc_en_r;
  logic [3:0]        idx_r;
  logic              wr_en_r;
  logic [ADDR_W-1:0] wr_addr_r;
  logic [7:0]        wr_data_r;
  logic [ADDR_W-1:0] next_pc_r;
  logic              halted_r;
  logic              mem_error_r;
  logic              instr_invalid_r;
  logic [31:0]       instr_count_r;

  logic [3:0]        len_s;
  logic              has_regs_s;
  logic              has_valc_s;
  logic              valid_s;
  logic              accept_s;
  logic              overrun_s;
  logic [ADDR_W-1:0] emit_addr_s;
  logic [7:0]        emit_byte_s;

  y86_instr_len u_len (
    .icode    (bus.in_icode),
    .len      (len_s),
    .has_regs (has_regs_s),
    .has_valc (has_valc_s),
    .valid    (valid_s)
  );

  assign accept_s    = bus.in_valid && (state_r == IDLE);
  // One extra bit so an instruction ending near the top of the address space cannot wrap past the check.
  assign overrun_s   = ({1'b0, next_pc_r} + {{(ADDR_W-3){1'b0}}, len_s}) > MEM_LIMIT;
  assign emit_addr_s = next_pc_r + {{(ADDR_W-4){1'b0}}, idx_r};
  assign emit_byte_s = instr_byte(icode_r, ifun_r, ra_r, rb_r, valc_r, regs_r, valc_en_r, idx_r);

  // Accept/emit/stop sequencing with every output held in a register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r         <= IDLE;
      icode_r         <= 4'h0;
      ifun_r          <= 4'h0;
      ra_r            <= REG_NONE;
      rb_r            <= REG_NONE;
      valc_r          <= 64'd0;
      len_r           <= 4'd0;
      regs_r          <= 1'b0;
      valc_en_r       <= 1'b0;
      idx_r           <= 4'd0;
      wr_en_r         <= 1'b0;
      wr_addr_r       <= {ADDR_W{1'b0}};
      wr_data_r       <= 8'h00;
      next_pc_r       <= START_ADDR;
      halted_r        <= 1'b0;
      mem_error_r     <= 1'b0;
      instr_invalid_r <= 1'b0;
      instr_count_r   <= 32'd0;
    end else begin
      instr_invalid_r <= 1'b0;
      case (state_r)
        IDLE: begin
          wr_en_r <= 1'b0;
          if (accept_s) begin
            if (!valid_s) begin
              instr_invalid_r <= 1'b1;
            end else if (overrun_s) begin
              mem_error_r <= 1'b1;
              state_r     <= STOP;
            end else begin
              icode_r   <= bus.in_icode;
              ifun_r    <= bus.in_ifun;
              ra_r      <= bus.in_rA;
              rb_r      <= bus.in_rB;
              valc_r    <= bus.in_valC;
              len_r     <= len_s;
              regs_r    <= has_regs_s;
              valc_en_r <= has_valc_s;
              idx_r     <= 4'd0;
              state_r   <= EMIT;
            end
          end
        end
        EMIT: begin
          wr_en_r   <= 1'b1;
          wr_addr_r <= emit_addr_s;
          wr_data_r <= emit_byte_s;
          // The last byte goes out on the same edge that retires the instruction.
          if (idx_r == (len_r - 4'd1)) begin
            next_pc_r     <= next_pc_r + {{(ADDR_W-4){1'b0}}, len_r};
            instr_count_r <= instr_count_r + 32'd1;
            if (icode_r == I_HALT) begin
              halted_r <= 1'b1;
              state_r  <= STOP;
            end else begin
              state_r <= IDLE;
            end
          end else begin
            idx_r <= idx_r + 4'd1;
          end
        end
        STOP: begin
          wr_en_r <= 1'b0;
        end
        default: begin
          wr_en_r <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready  = (state_r == IDLE);
  assign bus.wr_en     = wr_en_r;
  assign bus.wr_addr   = wr_addr_r;
  assign bus.wr_data   = wr_data_r;
  assign next_pc       = next_pc_r;
  assign halted        = halted_r;
  assign mem_error     = mem_error_r;
  assign instr_invalid = instr_invalid_r;
  assign instr_count   = instr_count_r;

endmodule

// File: tb/tb_y86_instr_encoder.sv
// Directed bench for y86_instr_encoder: a byte-list model checked every cycle
// plus hand-computed expectations for the listed scenarios.
module tb_y86_instr_encoder;

  typedef struct {
    bit          last;
    bit          halt;
    logic [63:0] addr;
    logic [7:0]  data;
    int          len;
  } ev_t;

  localparam logic [63:0] MEM = 64'd1024;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  y86_instr_encoder_if #(.ADDR_W(64)) bus_a ();
  y86_instr_encoder_if #(.ADDR_W(64)) bus_b ();

  logic [63:0] pc_a, pc_b;
  logic        halt_a, halt_b, err_a, err_b, inv_a, inv_b;
  logic [31:0] cnt_a, cnt_b;

  y86_instr_encoder #(.ADDR_W(64), .MEM_SIZE(1024), .START_ADDR(64'd0)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(bus_a), .next_pc(pc_a), .halted(halt_a),
    .mem_error(err_a), .instr_invalid(inv_a), .instr_count(cnt_a));

  y86_instr_encoder #(.ADDR_W(64), .MEM_SIZE(1024), .START_ADDR(64'd1016)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(bus_b), .next_pc(pc_b), .halted(halt_b),
    .mem_error(err_b), .instr_invalid(inv_b), .instr_count(cnt_b));

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model state for dut_a
  logic        m_ready = 1'b1, m_we = 1'b0;
  logic [63:0] m_addr = 64'd0, m_pc = 64'd0;
  logic [7:0]  m_data = 8'h00;
  logic        m_halt = 1'b0, m_err = 1'b0, m_inv = 1'b0, m_stop = 1'b0;
  logic [31:0] m_cnt = 32'd0;
  int          m_acc = 0;
  ev_t         sched[$];
  bit          started = 1'b0;

  initial begin : model
    logic [7:0] b[$];
    ev_t        ev;
    logic [3:0] ic;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_ready = 1'b1; m_we = 1'b0; m_addr = 64'd0; m_data = 8'h00; m_pc = 64'd0;
        m_cnt = 32'd0; m_halt = 1'b0; m_err = 1'b0; m_inv = 1'b0; m_stop = 1'b0;
        sched.delete();
      end else begin
        m_inv = 1'b0;
        if (sched.size() != 0) begin
          ev = sched.pop_front();
          m_we = 1'b1; m_addr = ev.addr; m_data = ev.data;
          if (ev.last) begin
            m_pc  = m_pc + 64'(ev.len);
            m_cnt = m_cnt + 32'd1;
            if (ev.halt) begin m_halt = 1'b1; m_stop = 1'b1; end
          end
        end else begin
          m_we = 1'b0;
          if (!m_stop && bus_a.in_valid) begin
            m_acc++;
            ic = bus_a.in_icode;
            if (ic > 4'hB) begin
              m_inv = 1'b1;
            end else begin
              b.delete();
              b.push_back({ic, bus_a.in_ifun});
              if (ic inside {4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'hA, 4'hB})
                b.push_back({bus_a.in_rA, bus_a.in_rB});
              if (ic inside {4'h3, 4'h4, 4'h5, 4'h7, 4'h8})
                for (int i = 0; i < 8; i++) b.push_back(bus_a.in_valC[8*i +: 8]);
              if (m_pc + 64'(b.size()) > MEM) begin
                m_err = 1'b1; m_stop = 1'b1;
              end else begin
                for (int i = 0; i < b.size(); i++)
                  sched.push_back('{last: (i == b.size() - 1), halt: (ic == 4'h0),
                                    addr: m_pc + 64'(i), data: b[i], len: b.size()});
              end
            end
          end
        end
        m_ready = (sched.size() == 0) && !m_stop;
      end
    end
  end

  // Per-cycle comparison of dut_a against the model
  initial forever begin
    @(negedge clk);
    if (started) begin
      chk("in_ready", bus_a.in_ready, m_ready);
      chk("wr_en", bus_a.wr_en, m_we);
      chk("wr_addr", bus_a.wr_addr, m_addr);
      chk("wr_data", bus_a.wr_data, m_data);
      chk("next_pc", pc_a, m_pc);
      chk("halted", halt_a, m_halt);
      chk("mem_error", err_a, m_err);
      chk("instr_invalid", inv_a, m_inv);
      chk("instr_count", cnt_a, m_cnt);
    end
  end

  logic [7:0] log_a [0:63];
  int         cyc_a [0:63];
  int         cyc = 0;
  bit         seen_b = 1'b0;

  initial forever begin
    @(negedge clk);
    cyc++;
    if (bus_a.wr_en === 1'b1 && bus_a.wr_addr < 64'd64) begin
      log_a[bus_a.wr_addr[5:0]] = bus_a.wr_data;
      cyc_a[bus_a.wr_addr[5:0]] = cyc;
    end
    if (bus_b.wr_en === 1'b1) seen_b = 1'b1;
  end

  task automatic clear_log();
    for (int i = 0; i < 64; i++) begin log_a[i] = 8'hAA; cyc_a[i] = 0; end
  endtask

  task automatic set_a(input logic [3:0] ic, input logic [3:0] fn, input logic [3:0] ra,
                       input logic [3:0] rb, input logic [63:0] vc);
    bus_a.in_icode = ic; bus_a.in_ifun = fn; bus_a.in_rA = ra; bus_a.in_rB = rb; bus_a.in_valC = vc;
  endtask

  task automatic send(input bit keep);
    int start;
    bit got;
    start = m_acc;
    got   = 1'b0;
    bus_a.in_valid = 1'b1;
    for (int i = 0; i < 40 && !got; i++) begin
      @(posedge clk); #1;
      if (m_acc != start) got = 1'b1;
    end
    chk("accept_timeout", got, 1'b1);
    if (!keep) bus_a.in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    bit done;
    done = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      if (m_ready || m_stop) done = 1'b1;
      else begin @(posedge clk); #1; end
    end
    chk("idle_timeout", done, 1'b1);
  endtask

  logic [7:0] ir_exp [0:9]    = '{8'h30, 8'hF2, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
  logic [7:0] call_exp [0:10] = '{8'h80, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01, 8'h62, 8'h34};

  initial begin
    int low;
    int hi;
    bus_a.in_valid = 1'b0;
    set_a(4'h1, 4'h0, 4'hF, 4'hF, 64'd0);
    bus_b.in_valid = 1'b0; bus_b.in_icode = 4'h4; bus_b.in_ifun = 4'h0;
    bus_b.in_rA = 4'h1; bus_b.in_rB = 4'h2; bus_b.in_valC = 64'd8;
    clear_log();
    #1 rst_n = 1'b0; started = 1'b1;
    #1;
    chk("rst_in_ready", bus_a.in_ready, 1'b1);
    chk("rst_wr_en", bus_a.wr_en, 1'b0);
    chk("rst_next_pc_a", pc_a, 64'd0);
    chk("rst_next_pc_b", pc_b, 64'd1016);
    chk("rst_count", cnt_a, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // Overrun on the instance starting at 1016
    bus_b.in_valid = 1'b1;
    @(posedge clk); #1 bus_b.in_valid = 1'b0;
    repeat (4) @(posedge clk); #1;
    chk("ovr_no_write", seen_b, 1'b0);
    chk("ovr_mem_error", err_b, 1'b1);
    chk("ovr_next_pc", pc_b, 64'd1016);
    chk("ovr_in_ready", bus_b.in_ready, 1'b0);
    chk("ovr_count", cnt_b, 32'd0);

    // nop
    set_a(4'h1, 4'h0, 4'hF, 4'hF, 64'd0);
    send(1'b0); wait_idle();
    @(negedge clk);
    chk("nop_byte", log_a[0], 8'h10);
    chk("nop_next_pc", pc_a, 64'd1);
    chk("nop_count", cnt_a, 32'd1);
    @(posedge clk); #1;

    // irmovq $0xFF, %rdx
    set_a(4'h3, 4'h0, 4'hF, 4'h2, 64'hFF);
    send(1'b0);
    low = 0;
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      if (!bus_a.in_ready) low++;
    end
    @(posedge clk); #1;
    wait_idle();
    chk("irmov_ready_low", 64'(low), 64'd10);
    for (int i = 0; i < 10; i++) chk("irmov_byte", log_a[1+i], ir_exp[i]);
    chk("irmov_next_pc", pc_a, 64'd11);

    // call then OPq with in_valid held; fields change right after the first accept
    set_a(4'h8, 4'h0, 4'hF, 4'hF, 64'h0100000000000000);
    send(1'b1);
    set_a(4'h6, 4'h2, 4'h3, 4'h4, 64'hDEAD);
    send(1'b0);
    wait_idle();
    @(negedge clk);
    for (int i = 0; i < 11; i++) chk("call_op_byte", log_a[11+i], call_exp[i]);
    chk("call_op_gap", 64'(cyc_a[20] - cyc_a[19]), 64'd2);
    chk("call_op_next_pc", pc_a, 64'd22);
    chk("call_op_count", cnt_a, 32'd4);
    @(posedge clk); #1;

    // invalid icode 0xC
    set_a(4'hC, 4'h0, 4'h1, 4'h2, 64'd0);
    send(1'b0);
    @(negedge clk);
    chk("inv_pulse", inv_a, 1'b1);
    chk("inv_ready", bus_a.in_ready, 1'b1);
    chk("inv_no_write", bus_a.wr_en, 1'b0);
    @(negedge clk);
    chk("inv_pulse_end", inv_a, 1'b0);
    chk("inv_next_pc", pc_a, 64'd22);
    @(posedge clk); #1;

    // mrmovq interrupted by reset while byte 4 is on the port
    set_a(4'h5, 4'h0, 4'h1, 4'h2, 64'h0807060504030201);
    send(1'b0);
    repeat (5) @(posedge clk);
    #2;
    chk("mid_wr_addr", bus_a.wr_addr, 64'd26);
    chk("mid_wr_data", bus_a.wr_data, 8'h03);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_wr_en", bus_a.wr_en, 1'b0);
    chk("mid_rst_next_pc", pc_a, 64'd0);
    chk("mid_rst_ready", bus_a.in_ready, 1'b1);
    chk("mid_rst_count", cnt_a, 32'd0);
    clear_log();
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;
    set_a(4'h1, 4'h0, 4'hF, 4'hF, 64'd0);
    send(1'b0); wait_idle();
    @(negedge clk);
    chk("post_rst_nop", log_a[0], 8'h10);
    chk("post_rst_next_pc", pc_a, 64'd1);
    @(posedge clk); #1;

    // halt, then in_valid held while stopped, then reset clears halted
    set_a(4'h0, 4'h0, 4'hF, 4'hF, 64'd0);
    send(1'b0); wait_idle();
    @(negedge clk);
    chk("halt_byte", log_a[1], 8'h00);
    chk("halt_flag", halt_a, 1'b1);
    set_a(4'h1, 4'h0, 4'hF, 4'hF, 64'd0);
    bus_a.in_valid = 1'b1;
    hi = 0;
    repeat (5) begin
      @(negedge clk);
      if (bus_a.in_ready || bus_a.wr_en) hi++;
    end
    bus_a.in_valid = 1'b0;
    chk("halt_blocked", 64'(hi), 64'd0);
    chk("halt_count", cnt_a, 32'd2);
    @(posedge clk); #2 rst_n = 1'b0;
    #1;
    chk("halt_rst_cleared", halt_a, 1'b0);
    chk("halt_rst_ready", bus_a.in_ready, 1'b1);
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/y86_instr_encoder.md
Name: y86_instr_encoder

Overview:
Serialises one decoded Y86-64 instruction into its byte encoding, producing one byte per clock. The input fields are icode, ifun, rA, rB and valC, and the output is an instruction-memory write port. It is the inverse of the SEQ fetch decode, and it loads programs into instruction memory for the SEQ/PIPE benches and for the boot loader. Bytes are written at consecutive addresses starting at START_ADDR.

Parameters:
ADDR_W, 64, width of the write address and next_pc.
MEM_SIZE, 1024, instruction memory size in bytes; valid addresses are 0..MEM_SIZE-1.
START_ADDR, 0, address of the first byte written after reset.

Ports:
clk  in  1  clock; all state updates on the rising edge.
rst_n  in  1  reset; asynchronous, active-low.
in_valid  in  1  an instruction is presented on the in_* fields.
in_ready  out  1  the encoder accepts an instruction this cycle.
in_icode  in  4  instruction code.
in_ifun  in  4  function code.
in_rA  in  4  register A (0xF = none).
in_rB  in  4  register B (0xF = none).
in_valC  in  64  constant or destination.
wr_en  out  1  a byte write to instruction memory is valid this cycle.
wr_addr  out  ADDR_W  byte address of the write.
wr_data  out  8  byte to write.
next_pc  out  ADDR_W  address where the next instruction will start.
halted  out  1  sticky; a halt instruction has been fully written.
mem_error  out  1  sticky; an accepted instruction would overrun MEM_SIZE.
instr_invalid  out  1  one-cycle pulse; the accepted icode is greater than 0xB.
instr_count  out  32  number of instructions fully written.

Behaviour:
- Reset values: in_ready=1, wr_en=0, wr_addr=0, wr_data=0, next_pc=START_ADDR, halted=0, mem_error=0, instr_invalid=0, instr_count=0, state=IDLE.
- States: IDLE, EMIT, STOP. in_ready = (state==IDLE).
- Accept: in_valid && in_ready at edge T. The encoder latches all in_* fields and computes len:
  - len=1 for icode 0 (halt), 1 (nop) and 9 (ret).
  - len=2 for icode 2 (cmov), 6 (OPq), A (pushq) and B (popq).
  - len=10 for icode 3 (irmovq), 4 (rmmovq) and 5 (mrmovq).
  - len=9 for icode 7 (jXX) and 8 (call).
- Byte order within an instruction:
  - byte0 = {icode, ifun}.
  - If the instruction has a register byte: byte1 = {rA, rB}, written verbatim with no forcing of 0xF.
  - valC follows, little-endian: least-significant byte first, 8 bytes.
- EMIT: wr_en=1 on the cycles after edges T+1 .. T+len (len consecutive cycles). wr_addr = next_pc + k for k = 0..len-1, and wr_data is byte k. All outputs are registered.
- Completion, on the edge after the last byte:
  - next_pc += len and instr_count += 1.
  - State returns to IDLE, so in_ready=1 again. Throughput is 1 instruction per len+1 cycles.
- Halt: when the final (only) byte of a halt has been written, halted goes to 1 and state goes to STOP. In STOP, in_ready=0 and wr_en=0, and only rst_n leaves STOP.
- Overrun: if next_pc + len > MEM_SIZE at accept, the encoder writes no bytes.
  - mem_error goes to 1 and state goes to STOP.
  - next_pc and instr_count are unchanged.
  - The check uses an ADDR_W+1-bit sum so it cannot wrap.
- Invalid icode (0xC–0xF): the instruction is accepted, instr_invalid pulses for exactly one cycle (the cycle after accept), and no bytes are written. next_pc and instr_count are unchanged and state stays IDLE.
- in_* fields are ignored whenever in_ready=0, and an in_valid held high in that case is not accepted. After acceptance the latched copy is used, so later changes to in_* do not affect the bytes being written.
- Reset asserted mid-EMIT: all outputs return immediately (asynchronously) to their reset values. Bytes already written stay in memory; the encoder does not roll them back.
- wr_addr and wr_data hold their last values while wr_en=0.

Decomposition:
- Shared package y86_pkg holds:
  - The icode constants: I_HALT=0, I_NOP=1, I_CMOV=2, I_IRMOV=3, I_RMMOV=4, I_MRMOV=5, I_OP=6, I_JXX=7, I_CALL=8, I_RET=9, I_PUSH=A, I_POP=B.
  - The constant REG_NONE=4'hF.
  - The FSM state encoding.
- One combinational sub-module, y86_instr_len. It takes icode and returns len[3:0], has_regs, has_valC and valid. The fetch stage reuses it.

Test Plan:
- Nop at START_ADDR=0 -> one wr_en cycle with addr 0 and data 0x10; next_pc=1 and instr_count=1.
- irmovq with rA=F, rB=2, valC=0xFF -> 10 writes at addr 0..9 with data 30,F2,FF,00,00,00,00,00,00,00; next_pc=10; in_ready stays low for 10 cycles after accept.
- Back-to-back call with valC=0x0100000000000000 (in_valid held high) followed by OPq with ifun=2, rA=3, rB=4 -> bytes 80,00,00,00,00,00,00,00,01 then 62,34 at contiguous addresses; 1 idle cycle between the two instructions.
- Halt -> single write of 0x00; halted=1 the next cycle; in_ready stays 0 even with in_valid=1; reset clears halted.
- START_ADDR=1016 and rmmovq -> no wr_en, mem_error=1, next_pc stays 1016. Separately, icode 0xC -> a single instr_invalid pulse, no write, in_ready=1 in the following cycle.
- rst_n pulled low during byte 4 of an mrmovq -> wr_en drops immediately, next_pc=START_ADDR, state=IDLE; a nop issued next is written at START_ADDR.
